eq_band_mixer: RTL and testbench

Parametrised N-band recombiner for the equaliser output stage. Collects one signed sample per enabled band, each on its own ready strobe and in any arrival order, sums them through a two-stage pipeline and emits one `out_rdy` pulse per completed set. Sits after the per-band gain/control blocks and feeds the DAC-side Wishbone/audio path. Replaces the fixed two-band adder: bands need not arrive in the same cycle, and it adds band masking, overrun detection and optional clipping.

---
 rtl/eq_band_mixer.sv | 130 +++++++++++++
 tb/tb_eq_band_mixer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/eq_band_mixer.sv
// N-band recombiner: collects one signed sample per enabled band in any order,
// sums the set through a two-stage pipeline. Optional clamping: EQMIX_SAT_EN.
module eq_band_mixer #(
  parameter int NBANDS = 3,
  parameter int IN_W   = 24,
  parameter int OUT_W  = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NBANDS*IN_W-1:0] in_band,
  input  logic [NBANDS-1:0]      in_rdy,
  input  logic [NBANDS-1:0]      band_en,
  output logic [OUT_W-1:0]       out_mix,
  output logic                   out_rdy,
  output logic                   clip,
  output logic [NBANDS-1:0]      ovr
);

  localparam int ACC_W = IN_W + $clog2(NBANDS);

  logic signed [IN_W-1:0]  hold_q [NBANDS];
  logic signed [IN_W-1:0]  hold_d [NBANDS];
  logic [NBANDS-1:0]       got_q, got_d;
  logic [NBANDS-1:0]       ovr_q, ovr_d;
  logic [NBANDS-1:0]       take;
  logic                    fire;
  logic                    vld_p0_q, vld_p0_d;
  logic signed [ACC_W-1:0] acc_p1_q, acc_p1_d;
  logic                    vld_p1_q, vld_p1_d;
  logic [OUT_W-1:0]        out_mix_p2_q, out_mix_p2_d;
  logic                    vld_p2_q, vld_p2_d;

  // Collection: capture strobes, detect a completed set, flag overruns
  always_comb begin
    take     = in_rdy & band_en;
    fire     = (band_en != '0) && ((got_q | take) == band_en);
    for (int i = 0; i < NBANDS; i++) begin
      hold_d[i] = take[i] ? in_band[i*IN_W +: IN_W] : hold_q[i];
    end
    got_d    = fire ? '0 : ((got_q | take) & band_en);
    ovr_d    = ovr_q | (take & got_q & {NBANDS{~fire}});
    vld_p0_d = fire;
  end

  // Stage 1: exact sum of the enabled holds
  always_comb begin
    acc_p1_d = acc_p1_q;
    vld_p1_d = vld_p0_q;
    if (vld_p0_q) begin
      acc_p1_d = '0;
      for (int i = 0; i < NBANDS; i++) begin
        if (band_en[i]) acc_p1_d = acc_p1_d + ACC_W'(hold_q[i]);
      end
    end
  end

`ifdef EQMIX_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic             clip_p2_q, clip_p2_d;
  logic [OUT_W:0]   fmt_res;

  // Returns {clipped, value}
  function automatic logic [OUT_W:0] fmt(input logic signed [ACC_W-1:0] a);
    if (a > SAT_HI) return {1'b1, SAT_HI[OUT_W-1:0]};
    if (a < SAT_LO) return {1'b1, SAT_LO[OUT_W-1:0]};
    return {1'b0, a[OUT_W-1:0]};
  endfunction

  // Stage 2: clamp to the output range
  always_comb begin
    fmt_res      = fmt(acc_p1_q);
    out_mix_p2_d = vld_p1_q ? fmt_res[OUT_W-1:0] : out_mix_p2_q;
    clip_p2_d    = vld_p1_q & fmt_res[OUT_W];
    vld_p2_d     = vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) clip_p2_q <= 1'b0;
    else       clip_p2_q <= clip_p2_d;
  end

  assign clip = clip_p2_q;
`else
  function automatic logic [OUT_W-1:0] fmt(input logic [OUT_W-1:0] a);
    return a;
  endfunction

  // Stage 2: wrap to the output width
  always_comb begin
    out_mix_p2_d = vld_p1_q ? fmt(acc_p1_q[OUT_W-1:0]) : out_mix_p2_q;
    vld_p2_d     = vld_p1_q;
  end

  if (ACC_W > OUT_W) begin : g_wrap_hi
    logic unused_acc_hi;
    assign unused_acc_hi = ^acc_p1_q[ACC_W-1:OUT_W];
  end

  assign clip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBANDS; i++) hold_q[i] <= '0;
      got_q        <= '0;
      ovr_q        <= '0;
      vld_p0_q     <= 1'b0;
      acc_p1_q     <= '0;
      vld_p1_q     <= 1'b0;
      out_mix_p2_q <= '0;
      vld_p2_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NBANDS; i++) hold_q[i] <= hold_d[i];
      got_q        <= got_d;
      ovr_q        <= ovr_d;
      vld_p0_q     <= vld_p0_d;
      acc_p1_q     <= acc_p1_d;
      vld_p1_q     <= vld_p1_d;
      out_mix_p2_q <= out_mix_p2_d;
      vld_p2_q     <= vld_p2_d;
    end
  end

  assign out_mix = out_mix_p2_q;
  assign out_rdy = vld_p2_q;
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Bench for eq_band_mixer: vector table, directed multi-cycle sequences and
// randomized traffic against a set-level reference model.
module tb_eq_band_mixer;
  localparam int NB = 3;
  localparam int IW = 24;
  localparam int OW = 24;
  localparam longint MASK = (64'sd1 <<< OW) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [NB*IW-1:0] in_band;
  logic [NB-1:0]    in_rdy, band_en;
  logic [OW-1:0]    out_mix;
  logic             out_rdy, clip;
  logic [NB-1:0]    ovr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  eq_band_mixer #(.NBANDS(NB), .IN_W(IW), .OUT_W(OW)) dut (
    .clk(clk), .reset(reset), .in_band(in_band), .in_rdy(in_rdy),
    .band_en(band_en), .out_mix(out_mix), .out_rdy(out_rdy), .clip(clip), .ovr(ovr)
  );

  // Reference model state: per-band latest sample and arrival, plus the
  // two in-flight sets (one awaiting summation, one awaiting output).
  longint      m_hold [NB];
  bit [NB-1:0] m_got, m_ovr;
  bit          m_set_done, m_sum_ready, m_exp_rdy, m_exp_clip;
  longint      m_sum, m_exp_mix;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void fmt_model(input longint s, output longint v, output bit c);
    longint hi, lo;
    hi = (64'sd1 <<< (OW-1)) - 1;
    lo = -hi - 1;
`ifdef EQMIX_SAT_EN
    if (s > hi)      begin v = hi; c = 1'b1; end
    else if (s < lo) begin v = lo; c = 1'b1; end
    else             begin v = s;  c = 1'b0; end
`else
    v = s & MASK;
    if (v > hi) v = v - (64'sd1 <<< OW);
    c = 1'b0;
`endif
  endfunction

  task automatic model_edge();
    bit [NB-1:0] take;
    bit          complete;
    longint      s;
    if (reset) begin
      for (int i = 0; i < NB; i++) m_hold[i] = 0;
      m_got = '0; m_ovr = '0;
      m_set_done = 0; m_sum_ready = 0; m_exp_rdy = 0; m_exp_clip = 0;
      m_sum = 0; m_exp_mix = 0;
    end else begin
      m_exp_rdy = m_sum_ready;
      if (m_sum_ready) fmt_model(m_sum, m_exp_mix, m_exp_clip);
      else m_exp_clip = 1'b0;
      if (m_set_done) begin
        s = 0;
        for (int i = 0; i < NB; i++) if (band_en[i]) s += m_hold[i];
        m_sum = s;
      end
      m_sum_ready = m_set_done;
      take = in_rdy & band_en;
      complete = (band_en != '0) && ((m_got | take) == band_en);
      for (int i = 0; i < NB; i++) begin
        if (take[i]) begin
          if (m_got[i] && !complete) m_ovr[i] = 1'b1;
          m_hold[i] = longint'($signed(in_band[i*IW +: IW]));
        end
      end
      m_got = complete ? '0 : ((m_got | take) & band_en);
      m_set_done = complete;
    end
  endtask

  task automatic tick(input bit rst, input logic [NB-1:0] rdy, input logic [NB-1:0] en,
                      input int b0, input int b1, input int b2);
    reset   = rst;
    in_rdy  = rdy;
    band_en = en;
    in_band = {24'(b2), 24'(b1), 24'(b0)};
    @(posedge clk);
    model_edge();
    #1;
    chk("m_out_rdy", out_rdy, m_exp_rdy);
    chk("m_out_mix", out_mix, m_exp_mix & MASK);
    chk("m_clip", clip, m_exp_clip);
    chk("m_ovr", ovr, m_ovr);
  endtask

  typedef struct {
    logic [NB-1:0] en;
    int            b0, b1, b2;
    logic [OW-1:0] mix;
    logic          clp;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [NB-1:0] en_cur, rdy, take;
    int v [NB];

    tbl[0] = '{3'b111, 100, -30, 5, 24'd75, 1'b0};
    tbl[1] = '{3'b101, 40, 999, -15, 24'd25, 1'b0};
`ifdef EQMIX_SAT_EN
    tbl[2] = '{3'b111, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF, 24'h7FFFFF, 1'b1};
    tbl[3] = '{3'b111, 'h800000, 'h800000, 'h800000, 24'h800000, 1'b1};
`else
    tbl[2] = '{3'b111, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF, 24'h7FFFFD, 1'b0};
    tbl[3] = '{3'b111, 'h800000, 'h800000, 'h800000, 24'h800000, 1'b0};
`endif
    tbl[4] = '{3'b011, -7, 3, 12345, 24'hFFFFFC, 1'b0};

    tick(1, '0, '0, 0, 0, 0);
    tick(1, '0, '0, 0, 0, 0);
    chk("rst_out_mix", out_mix, 0);
    chk("rst_out_rdy", out_rdy, 0);
    chk("rst_clip", clip, 0);
    chk("rst_ovr", ovr, 0);

    // Table: one complete set per record, pulse expected two edges later
    for (int k = 0; k < 5; k++) begin
      tick(0, 3'b111, tbl[k].en, tbl[k].b0, tbl[k].b1, tbl[k].b2);
      chk("tbl_no_early", out_rdy, 0);
      tick(0, '0, tbl[k].en, 0, 0, 0);
      chk("tbl_no_early", out_rdy, 0);
      tick(0, '0, tbl[k].en, 0, 0, 0);
      chk("tbl_rdy", out_rdy, 1);
      chk("tbl_mix", out_mix, tbl[k].mix);
      chk("tbl_clip", clip, tbl[k].clp);
      chk("tbl_ovr", ovr, 0);
      tick(0, '0, tbl[k].en, 0, 0, 0);
      chk("tbl_rdy_once", out_rdy, 0);
      chk("tbl_mix_hold", out_mix, tbl[k].mix);
    end

    // Staggered arrival: 7, then -2, then 1 -> 6 after edge 7
    for (int e = 0; e <= 7; e++) begin
      case (e)
        0: tick(0, 3'b001, 3'b111, 7, 0, 0);
        3: tick(0, 3'b100, 3'b111, 0, 0, -2);
        5: tick(0, 3'b010, 3'b111, 0, 1, 0);
        default: tick(0, 3'b000, 3'b111, 0, 0, 0);
      endcase
      if (e < 7) chk("stag_no_early", out_rdy, 0);
    end
    chk("stag_rdy", out_rdy, 1);
    chk("stag_mix", out_mix, 6);

    // Overrun on band0: the newer sample replaces the older one
    tick(0, 3'b001, 3'b111, 10, 0, 0);
    chk("ovr_none_yet", ovr, 3'b000);
    tick(0, 3'b001, 3'b111, 20, 0, 0);
    chk("ovr_set", ovr, 3'b001);
    tick(0, 3'b110, 3'b111, 0, 1, 2);
    tick(0, 3'b000, 3'b111, 0, 0, 0);
    chk("ovr_no_early", out_rdy, 0);
    tick(0, 3'b000, 3'b111, 0, 0, 0);
    chk("ovr_rdy", out_rdy, 1);
    chk("ovr_mix", out_mix, 23);
    tick(0, 3'b000, 3'b111, 0, 0, 0);
    chk("ovr_sticky", ovr, 3'b001);

    // Reset mid-collection discards bands already received
    tick(0, 3'b011, 3'b111, 50, 60, 0);
    tick(1, 3'b000, 3'b111, 0, 0, 0);
    chk("midrst_ovr", ovr, 0);
    chk("midrst_mix", out_mix, 0);
    tick(0, 3'b100, 3'b111, 0, 0, 70);
    for (int e = 0; e < 4; e++) begin
      tick(0, 3'b000, 3'b111, 0, 0, 0);
      chk("midrst_no_pulse", out_rdy, 0);
    end
    tick(0, 3'b111, 3'b111, 1, 2, 3);
    tick(0, 3'b000, 3'b111, 0, 0, 0);
    tick(0, 3'b000, 3'b111, 0, 0, 0);
    chk("midrst_rdy", out_rdy, 1);
    chk("midrst_mix6", out_mix, 6);

    // Randomized traffic against the model
    en_cur = 3'b111;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 24) == 0) en_cur = 3'($urandom_range(0, 7));
      rdy = 3'($urandom) & 3'($urandom);
      if ($urandom_range(0, 3) == 0) rdy = 3'b111;
      take = rdy & en_cur;
      // A repeat strobe from an already-collected band on a completing
      // edge is left out of random traffic.
      if (en_cur != '0 && ((m_got | take) == en_cur)) rdy = rdy & ~m_got;
      for (int i = 0; i < NB; i++) begin
        case ($urandom_range(0, 5))
          0: v[i] = 'h7FFFFF;
          1: v[i] = 'h800000;
          default: v[i] = int'($urandom);
        endcase
      end
      tick($urandom_range(0, 99) == 0, rdy, en_cur, v[0], v[1], v[2]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
